// File: rtl/pc_unit.sv
// pc_unit: program-counter unit for the single-cycle RISC-V core.
//
// Holds the fetch address and picks the next one each cycle. The options are
// the sequential PC+4, a branch target PC+(imm<<1), and a jump-register
// target (base+imm) with bit 0 cleared. A redirect whose target has bit 1 set
// is not taken. Instead the unit traps: the faulting PC and the bad target are
// captured, and the PC is loaded with TRAP_VECTOR for one cycle. Every
// non-trapping advance in RUN increments a wrapping fetch counter.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-low reset (0 = reset)
//   stall        hold PC and ignore redirects this cycle
//   branch_taken branch condition true
//   jalr         jump-register request (wins over branch_taken)
//   imm          sign-extended immediate
//   base         rs1 value for jalr
//   pc           current fetch address
//   pc_valid     pc is a fetchable address (RUN only)
//   trap         one-cycle pulse while pc sits at TRAP_VECTOR
//   epc          faulting PC captured on the last trap
//   bad_target   misaligned target captured on the last trap
//   fetch_count  number of PC advances made in RUN
module pc_unit #(
  parameter int              XLEN         = 64,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'('h100),
  parameter int              CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic             jalr,
  input  logic [XLEN-1:0]  imm,
  input  logic [XLEN-1:0]  base,
  output logic [XLEN-1:0]  pc,
  output logic             pc_valid,
  output logic             trap,
  output logic [XLEN-1:0]  epc,
  output logic [XLEN-1:0]  bad_target,
  output logic [CNT_W-1:0] fetch_count
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  epc_q, epc_d;
  logic [XLEN-1:0]  bad_q, bad_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [XLEN-1:0]  seq_target;
  logic [XLEN-1:0]  br_target;
  logic [XLEN-1:0]  jr_target;
  logic [XLEN-1:0]  target;
  logic             redirect;
  logic             misaligned;

  // Candidate targets, all in wrap-around XLEN arithmetic.
  assign seq_target = pc_q + XLEN'(4);
  assign br_target  = pc_q + (imm << 1);
  assign jr_target  = (base + imm) & ~XLEN'(1);

  assign redirect   = jalr | branch_taken;
  assign target     = jalr ? jr_target : (branch_taken ? br_target : seq_target);
  // Only redirects can be misaligned; the sequential target stays word aligned.
  assign misaligned = redirect & target[1];

  // Next-state logic. The trap path keeps the old PC in epc and loads
  // TRAP_VECTOR without counting the cycle as an advance.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    bad_d   = bad_q;
    cnt_d   = cnt_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (!stall) begin
          if (misaligned) begin
            epc_d   = pc_q;
            bad_d   = target;
            pc_d    = TRAP_VECTOR;
            state_d = TRAP;
          end else begin
            pc_d  = target;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      TRAP: state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  // State register; reset is sampled only at the clock edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      epc_q   <= '0;
      bad_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      bad_q   <= bad_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc          = pc_q;
  assign pc_valid    = (state_q == RUN);
  assign trap        = (state_q == TRAP);
  assign epc         = epc_q;
  assign bad_target  = bad_q;
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: self-checking bench for pc_unit.
//
// A behavioural model follows the PC rules directly and is compared against
// two DUT instances every cycle: one with the default 32-bit counter and one
// with a 4-bit counter. Directed sequences pin the model to hand-computed
// values, and a randomized run then covers the input space.
module tb_pc_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic        jalr;
  logic [63:0] imm;
  logic [63:0] base;

  logic [63:0] pc, epc, bad_target;
  logic        pc_valid, trap;
  logic [31:0] fetch_count;

  logic [63:0] pc4, epc4, bad4;
  logic        valid4, trap4;
  logic [3:0]  count4;

  int checkCount = 0;
  int passCount  = 0;

  // Model state
  bit          modelKnown = 0;
  bit          mBoot;
  bit          mTrap;
  bit          mValid;
  logic [63:0] mPc, mEpc, mBad;
  longint unsigned mAdvances;

  pc_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .jalr(jalr), .imm(imm), .base(base), .pc(pc), .pc_valid(pc_valid),
    .trap(trap), .epc(epc), .bad_target(bad_target), .fetch_count(fetch_count)
  );

  pc_unit #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .jalr(jalr), .imm(imm), .base(base), .pc(pc4), .pc_valid(valid4),
    .trap(trap4), .epc(epc4), .bad_target(bad4), .fetch_count(count4)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: what the PC must be after this edge, from the rules.
  always @(posedge clk) begin
    logic [63:0] tgt;
    bit          redir;
    if (!reset) begin
      modelKnown = 1;
      mBoot = 1; mTrap = 0; mValid = 0;
      mPc = 64'h0; mEpc = 0; mBad = 0; mAdvances = 0;
    end else if (modelKnown) begin
      if (mBoot) begin
        mBoot = 0; mValid = 1;
      end else if (mTrap) begin
        mTrap = 0; mValid = 1;
      end else if (!stall) begin
        redir = jalr || branch_taken;
        if (jalr)              tgt = ((base + imm) >> 1) * 2;
        else if (branch_taken) tgt = mPc + imm * 2;
        else                   tgt = mPc + 4;
        if (redir && (tgt % 4) >= 2) begin
          mEpc = mPc; mBad = tgt; mPc = 64'h100; mTrap = 1; mValid = 0;
        end else begin
          mPc = tgt; mAdvances++;
        end
      end
    end
  end

  // Compare process: checks both instances away from the active edge.
  always @(negedge clk) begin
    if (modelKnown) begin
      checkOutput("pc", pc, mPc);
      checkOutput("pc_valid", 64'(pc_valid), 64'(mValid));
      checkOutput("trap", 64'(trap), 64'(mTrap));
      checkOutput("epc", epc, mEpc);
      checkOutput("bad_target", bad_target, mBad);
      checkOutput("fetch_count", 64'(fetch_count), 64'(mAdvances % (64'd1 << 32)));
      checkOutput("pc_cnt4", pc4, mPc);
      checkOutput("fetch_count_cnt4", 64'(count4), 64'(mAdvances % 16));
    end
  end

  task automatic applyStimulus(input logic rst, input logic st, input logic br,
                               input logic jr, input logic [63:0] im, input logic [63:0] bs);
    reset = rst; stall = st; branch_taken = br; jalr = jr; imm = im; base = bs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] rImm, rBase;
    reset = 0; stall = 0; branch_taken = 0; jalr = 0; imm = 0; base = 0;

    // Reset, then boot cycle and sequential fetch.
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("lit_reset_pc", mPc, 64'h0);
    checkOutput("lit_reset_valid", 64'(pc_valid), 64'h0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("lit_boot_pc", mPc, 64'h0);
    repeat (3) applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("lit_seq_pc", mPc, 64'hC);
    checkOutput("lit_seq_count", mAdvances, 64'd3);

    // Branches forward and backward.
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 1, 0, 64'd8, 0);
    checkOutput("lit_br_fwd", mPc, 64'h20);
    applyStimulus(1, 0, 1, 0, -64'sd4, 0);
    checkOutput("lit_br_back", mPc, 64'h18);

    // jalr wins over branch; the misaligned target traps.
    applyStimulus(1, 0, 1, 1, 64'h2, 64'h1001);
    checkOutput("lit_trap_pc", mPc, 64'h100);
    checkOutput("lit_trap_flag", 64'(trap), 64'h1);
    checkOutput("lit_trap_epc", mEpc, 64'h18);
    checkOutput("lit_trap_bad", mBad, 64'h1002);
    applyStimulus(1, 1, 1, 1, 64'h40, 64'h0);
    checkOutput("lit_after_trap_pc", mPc, 64'h100);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("lit_after_trap_seq", mPc, 64'h104);

    // Stall freezes PC and counter.
    repeat (3) applyStimulus(1, 1, 1, 0, 64'h2, 0);
    checkOutput("lit_stall_pc", mPc, 64'h104);
    checkOutput("lit_stall_count", mAdvances, 64'd7);
    applyStimulus(1, 0, 1, 0, 64'h2, 0);
    checkOutput("lit_unstall_pc", mPc, 64'h108);

    // Back-to-back traps, then reset during a trap cycle.
    applyStimulus(1, 0, 1, 0, 64'h1, 0);
    checkOutput("lit_b2b_epc1", mEpc, 64'h108);
    checkOutput("lit_b2b_bad1", mBad, 64'h10A);
    applyStimulus(1, 0, 1, 0, 64'h1, 0);
    applyStimulus(1, 0, 1, 0, 64'h1, 0);
    checkOutput("lit_b2b_trap2", 64'(trap), 64'h1);
    checkOutput("lit_b2b_epc2", mEpc, 64'h100);
    applyStimulus(0, 0, 1, 0, 64'h1, 0);
    checkOutput("lit_rst_trap_pc", mPc, 64'h0);
    checkOutput("lit_rst_trap_flag", 64'(trap), 64'h0);
    checkOutput("lit_rst_trap_epc", mEpc, 64'h0);
    checkOutput("lit_rst_trap_count", mAdvances, 64'd0);

    // A reset glitch between edges must not be seen.
    applyStimulus(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1 reset = 0;
    #2 reset = 1;
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("lit_glitch_pc", mPc, 64'h4);
    checkOutput("lit_glitch_dut_pc", pc, 64'h4);

    // PC wrap-around through the top of the address space.
    applyStimulus(1, 0, 0, 1, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC);
    checkOutput("lit_top_pc", mPc, 64'hFFFF_FFFF_FFFF_FFFC);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("lit_wrap_pc", mPc, 64'h0);
    checkOutput("lit_wrap_trap", 64'(trap), 64'h0);

    // 16 advances wrap a 4-bit counter.
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    repeat (16) applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("lit_cnt4_wrap", 64'(count4), 64'h0);
    checkOutput("lit_cnt32_16", 64'(fetch_count), 64'd16);

    // Randomized run.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0:       rImm = {$urandom, $urandom};
        default: rImm = 64'($signed(10'($urandom)));
      endcase
      rBase = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 4095));
      applyStimulus(($urandom_range(0, 63) != 0), ($urandom_range(0, 4) == 0),
                    ($urandom_range(0, 2) == 0), ($urandom_range(0, 4) == 0), rImm, rBase);
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
